mlp_layer_engine: RTL and testbench

MLP_LAYER_ENGINE -- requirements
Module: mlp_layer_engine

---
 rtl/mlp_layer_engine.sv | 217 +++++++++++++++++++++
 tb/tb_mlp_layer_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_engine.sv
// Fully connected layer: LANES neurons at a time, one input element per cycle, then activation and saturation.
// Latency: first result IN_DIM+2 cycles after accept; each group of LANES neurons takes IN_DIM+1+LANES cycles with out_ready high.
// Backpressure: out_ready low freezes the OUT state and holds out_data/out_valid; in_ready is high only in IDLE without load_mode.
module mlp_layer_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int IN_DIM  = 63,
  parameter int OUT_DIM = 256,
  parameter int LANES   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_mode,
  input  logic                       load_valid,
  input  logic                       load_sel,
  input  logic [$clog2(OUT_DIM)-1:0] load_row,
  input  logic [$clog2(IN_DIM)-1:0]  load_col,
  input  logic [DATA_W-1:0]          load_data,
  input  logic [DATA_W*IN_DIM-1:0]   in_vec,
  input  logic [1:0]                 act_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic [15:0]                sat_count
);

  localparam int ROW_W  = $clog2(OUT_DIM);
  localparam int COL_W  = $clog2(IN_DIM);
  localparam int GROUPS = OUT_DIM / LANES;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  // Sum of IN_DIM full-width products cannot overflow this width.
  localparam int ACC_W  = 2*DATA_W + COL_W;
  // One extra bit so that adding the shifted bias cannot overflow either.
  localparam int YW     = ACC_W + 1;

  localparam logic [COL_W-1:0]  K_LAST = COL_W'(IN_DIM-1);
  localparam logic [GRP_W-1:0]  G_LAST = GRP_W'(GROUPS-1);
  localparam logic [LANE_W-1:0] L_LAST = LANE_W'(LANES-1);
  localparam logic signed [YW-1:0] Y_ONE  = YW'(1) <<< FRAC_W;
  localparam logic signed [YW-1:0] Y_HALF = YW'(1) <<< (FRAC_W-1);
  localparam logic signed [YW-1:0] Y_MAX  = (YW'(1) <<< (DATA_W-1)) - YW'(1);
  localparam logic signed [YW-1:0] Y_MIN  = -(YW'(1) <<< (DATA_W-1));

  typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

  state_t                    state_q, state_d;
  logic [GRP_W-1:0]          group_q, group_d;
  logic [COL_W-1:0]          k_q, k_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [1:0]                act_q, act_d;
  logic [15:0]               sat_cnt_q, sat_cnt_d;
  logic signed [ACC_W-1:0]   acc_q [LANES];
  logic signed [ACC_W-1:0]   acc_d [LANES];
  logic [DATA_W-1:0]         res_q [LANES];
  logic [DATA_W-1:0]         res_d [LANES];
  logic signed [DATA_W-1:0]  x_q [IN_DIM];
  logic signed [DATA_W-1:0]  x_d [IN_DIM];

  logic signed [DATA_W-1:0]  w_mem_q [OUT_DIM][IN_DIM];
  logic signed [DATA_W-1:0]  b_mem_q [OUT_DIM];
  logic                      mem_we;

  // Sign-extended full-precision product.
  function automatic logic signed [2*DATA_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ae;
    logic signed [2*DATA_W-1:0] be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  // Activation followed by saturation; MSB of the result flags a saturated value.
  function automatic logic [DATA_W:0] act_sat(input logic signed [YW-1:0] y, input logic [1:0] m);
    logic signed [YW-1:0] a;
    logic signed [YW-1:0] hs;
    hs = (y >>> 2) + Y_HALF;
    case (m)
      2'b01:   a = y[YW-1] ? '0 : y;
      2'b10:   a = hs[YW-1] ? '0 : ((hs > Y_ONE) ? Y_ONE : hs);
      2'b11:   a = y[YW-1] ? (y >>> 3) : y;
      default: a = y;
    endcase
    if (a > Y_MAX)      return {1'b1, Y_MAX[DATA_W-1:0]};
    else if (a < Y_MIN) return {1'b1, Y_MIN[DATA_W-1:0]};
    else                return {1'b0, a[DATA_W-1:0]};
  endfunction

  assign mem_we    = rst_n && load_mode && load_valid && (state_q == IDLE) &&
                     (int'(load_row) < OUT_DIM);
  assign in_ready  = (state_q == IDLE) && !load_mode;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = res_q[lane_q];
  assign out_last  = out_valid && (group_q == G_LAST) && (lane_q == L_LAST);
  assign sat_count = sat_cnt_q;

  // Parameter memories: written only from IDLE, never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (load_sel)                         b_mem_q[load_row] <= load_data;
      else if (int'(load_col) < IN_DIM)     w_mem_q[load_row][load_col] <= load_data;
    end
  end

  // Next-state, MAC datapath, activation and output sequencing.
  always_comb begin
    logic [ROW_W-1:0]      row_l;
    logic signed [YW-1:0]  sum_l;
    logic [DATA_W:0]       r_l;
    logic [15:0]           nsat;
    logic [16:0]           sum17;
    row_l     = '0;
    sum_l     = '0;
    r_l       = '0;
    nsat      = '0;
    sum17     = '0;
    state_d   = state_q;
    group_d   = group_q;
    k_d       = k_q;
    lane_d    = lane_q;
    act_d     = act_q;
    sat_cnt_d = sat_cnt_q;
    acc_d     = acc_q;
    res_d     = res_q;
    x_d       = x_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < IN_DIM; i++) x_d[i] = in_vec[i*DATA_W +: DATA_W];
          act_d   = act_mode;
          group_d = '0;
          k_d     = '0;
          acc_d   = '{default: '0};
          state_d = MAC;
        end
      end
      MAC: begin
        for (int l = 0; l < LANES; l++) begin
          row_l    = ROW_W'(int'(group_q) * LANES + l);
          acc_d[l] = acc_q[l] + ACC_W'(mul(w_mem_q[row_l][k_q], x_q[k_q]));
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ACT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ACT: begin
        for (int l = 0; l < LANES; l++) begin
          row_l    = ROW_W'(int'(group_q) * LANES + l);
          sum_l    = YW'(acc_q[l]) + (YW'(b_mem_q[row_l]) <<< FRAC_W);
          r_l      = act_sat(sum_l >>> FRAC_W, act_q);
          res_d[l] = r_l[DATA_W-1:0];
          nsat     = nsat + 16'(r_l[DATA_W]);
        end
        sum17     = {1'b0, sat_cnt_q} + {1'b0, nsat};
        sat_cnt_d = sum17[16] ? 16'hFFFF : sum17[15:0];
        lane_d    = '0;
        state_d   = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (lane_q == L_LAST) begin
            lane_d = '0;
            k_d    = '0;
            acc_d  = '{default: '0};
            if (group_q == G_LAST) begin
              group_d = '0;
              state_d = IDLE;
            end else begin
              group_d = group_q + 1'b1;
              state_d = MAC;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, accumulator and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      group_q   <= '0;
      k_q       <= '0;
      lane_q    <= '0;
      sat_cnt_q <= '0;
      acc_q     <= '{default: '0};
      res_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      group_q   <= group_d;
      k_q       <= k_d;
      lane_q    <= lane_d;
      sat_cnt_q <= sat_cnt_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
    end
  end

  // Captured input vector and activation mode; plain data, no reset needed.
  always_ff @(posedge clk) begin
    x_q   <= x_d;
    act_q <= act_d;
  end

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Scoreboard bench for mlp_layer_engine at DATA_W=16, FRAC_W=8, IN_DIM=4, OUT_DIM=4, LANES=2.
// Directed vectors push hand-computed results; a negedge monitor pops and compares each accepted beat.
// Covers reset, all activations, bias, truncation, saturation, stall, dropped loads and mid-run reset.
module tb_mlp_layer_engine;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int ID = 4;
  localparam int OD = 4;
  localparam int LN = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_mode, load_valid, load_sel;
  logic [1:0]      load_row, load_col;
  logic [DW-1:0]   load_data;
  logic [DW*ID-1:0] in_vec;
  logic [1:0]      act_mode;
  logic            in_valid, in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready, out_last, busy;
  logic [15:0]     sat_count;

  always #5 clk = ~clk;

  mlp_layer_engine #(.DATA_W(DW), .FRAC_W(FW), .IN_DIM(ID), .OUT_DIM(OD), .LANES(LN)) dut (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .load_valid(load_valid),
    .load_sel(load_sel), .load_row(load_row), .load_col(load_col), .load_data(load_data),
    .in_vec(in_vec), .act_mode(act_mode), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .sat_count(sat_count)
  );

  typedef struct packed {
    logic [15:0] dat;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  bit          lat_armed = 1'b0;
  bit          tot_armed = 1'b0;
  logic [15:0] wtab [4][4];
  logic [15:0] btab [4];

  localparam logic [15:0] X0 = 16'h0100;
  localparam logic [15:0] X1 = 16'h0200;
  localparam logic [15:0] X2 = 16'h0300;
  localparam logic [15:0] X3 = 16'h0400;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: latency of first beat, then scoreboard pop on every accepted beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (lat_armed) begin
        chk("first_valid_latency", 16'(cyc - accept_cyc), 16'd6);
        lat_armed = 1'b0;
      end
      if (out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %h, expected no beat", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_data, mon_e.dat);
          chk("out_last", 16'(out_last), 16'(mon_e.last));
          if (out_last === 1'b1 && tot_armed) begin
            chk("total_latency", 16'(cyc - accept_cyc), 16'd14);
            tot_armed = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic send(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                      input logic [15:0] x3, input logic [1:0] mode,
                      input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                      input logic [15:0] e3, input bit push, input bit tot);
    wait_idle();
    in_vec   = {x3, x2, x1, x0};
    act_mode = mode;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_at_accept", 16'(in_ready), 16'd1);
    if (push) begin
      exp_q.push_back(exp_t'{e0, 1'b0});
      exp_q.push_back(exp_t'{e1, 1'b0});
      exp_q.push_back(exp_t'{e2, 1'b0});
      exp_q.push_back(exp_t'{e3, 1'b1});
    end
    accept_cyc = cyc;
    lat_armed  = push;
    tot_armed  = push && tot;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run4(input logic [1:0] mode, input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2, input logic [15:0] e3);
    send(X0, X1, X2, X3, mode, e0, e1, e2, e3, 1'b1, 1'b1);
  endtask

  task automatic beat(input logic sel, input int r, input int c, input logic [15:0] d);
    load_mode  = 1'b1;
    load_valid = 1'b1;
    load_sel   = sel;
    load_row   = 2'(r);
    load_col   = 2'(c);
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load_all();
    wait_idle();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) beat(1'b0, r, c, wtab[r][c]);
    for (int r = 0; r < 4; r++) beat(1'b1, r, 3, btab[r]);
    load_mode = 1'b0;
  endtask

  task automatic fill_w(input logic [15:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wtab[r][c] = v;
  endtask

  task automatic fill_b(input logic [15:0] v);
    for (int r = 0; r < 4; r++) btab[r] = v;
  endtask

  task automatic set_w_ident();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wtab[r][c] = (r == c) ? 16'h0100 : 16'h0000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; load_mode = 1'b0; load_valid = 1'b0; load_sel = 1'b0;
    load_row = '0; load_col = '0; load_data = '0; in_vec = '0; act_mode = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_last", 16'(out_last), 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_sat_count", sat_count, 16'h0000);
    chk("rst_in_ready", 16'(in_ready), 16'd1);

    // Identity weights, zero bias, relu.
    set_w_ident(); fill_b(16'h0000); load_all();
    run4(2'b01, 16'h0100, 16'h0200, 16'h0300, 16'h0400);

    // Row 0 all -1.0 across every activation.
    for (int c = 0; c < 4; c++) wtab[0][c] = 16'hFF00;
    load_all();
    run4(2'b01, 16'h0000, 16'h0200, 16'h0300, 16'h0400);
    run4(2'b11, 16'hFEC0, 16'h0200, 16'h0300, 16'h0400);
    run4(2'b00, 16'hF600, 16'h0200, 16'h0300, 16'h0400);
    run4(2'b10, 16'h0000, 16'h0100, 16'h0100, 16'h0100);

    // Zero weights (hard-sigmoid midpoint) and -1/256 truncating toward -inf.
    fill_w(16'h0000); wtab[0][0] = 16'hFFFF; load_all();
    run4(2'b10, 16'h007F, 16'h0080, 16'h0080, 16'h0080);
    run4(2'b00, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);

    // Bias only.
    wtab[0][0] = 16'h0000;
    btab[0] = 16'h0100; btab[1] = 16'hFF00; btab[2] = 16'h0000; btab[3] = 16'h0280;
    load_all();
    run4(2'b00, 16'h0100, 16'hFF00, 16'h0000, 16'h0280);
    run4(2'b11, 16'h0100, 16'hFFE0, 16'h0000, 16'h0280);

    // Positive and negative saturation.
    fill_w(16'h7F00); fill_b(16'h0000); load_all();
    send(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 2'b01,
         16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    wait_idle();
    chk("sat_count_pos", sat_count, 16'd4);
    send(16'h8100, 16'h8100, 16'h8100, 16'h8100, 2'b00,
         16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1);
    wait_idle();
    chk("sat_count_neg", sat_count, 16'd8);

    // out_ready low for 5 cycles after the first beat.
    set_w_ident(); fill_b(16'h0000); load_all();
    send(X0, X1, X2, X3, 2'b01, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b1, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL stall_wait: out_valid=%b, expected 1", out_valid);
    end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", 16'(out_valid), 16'd1);
      chk("stall_out_data", out_data, 16'h0200);
      tick();
    end
    out_ready = 1'b1;

    // Load beat during MAC is dropped; rerun gives the same result.
    send(X0, X1, X2, X3, 2'b01, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b1, 1'b1);
    tick(); tick();
    beat(1'b0, 0, 0, 16'h7F00);
    load_mode = 1'b0;
    run4(2'b01, 16'h0100, 16'h0200, 16'h0300, 16'h0400);

    // in_valid has no effect while load_mode is high.
    wait_idle();
    load_mode = 1'b1; in_vec = {X3, X2, X1, X0}; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("loadmode_busy", 16'(busy), 16'd0);
      chk("loadmode_in_ready", 16'(in_ready), 16'd0);
    end
    in_valid = 1'b0; load_mode = 1'b0;

    // Reset during MAC; weights survive.
    send(X0, X1, X2, X3, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("macrst_out_valid", 16'(out_valid), 16'd0);
    chk("macrst_busy", 16'(busy), 16'd0);
    chk("macrst_in_ready", 16'(in_ready), 16'd1);
    chk("macrst_sat_count", sat_count, 16'h0000);
    chk("macrst_out_data", out_data, 16'h0000);
    rst_n = 1'b1;
    run4(2'b01, 16'h0100, 16'h0200, 16'h0300, 16'h0400);

    wait_idle();
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
